// File: rtl/f32div_seq.sv
// ----------------------------------------------------------------------------
// f32div_seq
// Sequential IEEE-754 binary32 divider, out = x / y.
// A radix-2 restoring divider produces one quotient bit per cycle. Subnormal
// inputs count as zero, subnormal results flush to zero, rounding is
// round-to-nearest-even, and every NaN result is the canonical 0x7FC00000.
// Latency from accept to out_valid is a fixed 27 cycles. Special cases also
// run all iterations, so latency does not depend on the data.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   x and y are presented
//   in_ready   block can accept operands (high only in IDLE)
//   x, y       dividend and divisor, binary32
//   out_valid  out holds a valid quotient (high only in DONE)
//   out_ready  consumer takes out
//   out        quotient, binary32; keeps its last value until the next result
// ----------------------------------------------------------------------------
module f32div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;

    state_t             state;
    logic        [4:0]  cnt;
    logic        [25:0] r;
    logic        [25:0] q;
    logic        [23:0] my_r;
    logic signed [9:0]  e_r;
    logic               sign_r;
    logic               spec_r;
    logic        [31:0] spec_val;

    // Operand decode. An exponent field of zero counts as zero.
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, sign_in;
    logic in_nan, in_inf, in_zero;
    logic [31:0] in_spec_val;

    assign x_zero  = (x[30:23] == 8'd0);
    assign y_zero  = (y[30:23] == 8'd0);
    assign x_inf   = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    assign y_inf   = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    assign x_nan   = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    assign y_nan   = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    assign sign_in = x[31] ^ y[31];

    // The checks are ordered by priority: invalid, then infinite, then zero.
    assign in_nan  = x_nan | y_nan | (x_inf & y_inf) | (x_zero & y_zero);
    assign in_inf  = x_inf | y_zero;
    assign in_zero = x_zero | y_inf;

    always_comb begin
        // NOTE: a default assignment on every path of always_comb prevents latch inference.
        in_spec_val = {sign_in, 31'd0};
        if (in_nan)
            in_spec_val = 32'h7FC0_0000;
        else if (in_inf)
            in_spec_val = {sign_in, 31'h7F80_0000};
    end

    // One restoring step: subtract the divisor when it fits, then shift.
    logic        r_ge;
    logic [25:0] r_sel;
    assign r_ge  = (r >= {2'b00, my_r});
    assign r_sel = r_ge ? (r - {2'b00, my_r}) : r;

    // Normalise and round, using the finished q, r and e.
    logic        [23:0] m_n;
    logic               guard, sticky, rnd_up;
    logic signed [9:0]  e_n, e_f;
    logic        [24:0] m_inc;
    logic        [23:0] m_f;
    logic        [31:0] result;

    always_comb begin
        m_n    = q[24:1];
        guard  = q[0];
        sticky = (r != 26'd0);
        e_n    = e_r - 10'sd1;
        // The quotient lies in [0.5, 2). q[25] set means it is already in [1, 2).
        if (q[25]) begin
            m_n    = q[25:2];
            guard  = q[1];
            sticky = q[0] | (r != 26'd0);
            e_n    = e_r;
        end
        rnd_up = guard & (sticky | m_n[0]);
        m_inc  = {1'b0, m_n} + {24'd0, rnd_up};
        m_f    = m_inc[23:0];
        e_f    = e_n;
        if (m_inc[24]) begin
            m_f = 24'h80_0000;
            e_f = e_n + 10'sd1;
        end
        if (spec_r)
            result = spec_val;
        else if (e_f >= 10'sd255)
            result = {sign_r, 31'h7F80_0000};
        else if (e_f <= 10'sd0)
            result = {sign_r, 31'd0};
        else
            result = {sign_r, e_f[7:0], m_f[22:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= 32'd0;
            cnt       <= 5'd0;
            r         <= 26'd0;
            q         <= 26'd0;
            my_r      <= 24'd0;
            e_r       <= 10'sd0;
            sign_r    <= 1'b0;
            spec_r    <= 1'b0;
            spec_val  <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments let every register here sample pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= DIV;
                        in_ready <= 1'b0;
                        cnt      <= 5'd0;
                        r        <= {2'b01, x[22:0]};
                        my_r     <= {1'b1, y[22:0]};
                        q        <= 26'd0;
                        e_r      <= $signed({2'b00, x[30:23]}) - $signed({2'b00, y[30:23]})
                                    + 10'sd127;
                        sign_r   <= sign_in;
                        spec_r   <= in_nan | in_inf | in_zero;
                        spec_val <= in_spec_val;
                    end
                end
                DIV: begin
                    r   <= {r_sel[24:0], 1'b0};
                    q   <= {q[24:0], r_ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd25)
                        state <= RND;
                end
                RND: begin
                    out       <= result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_f32div_seq.sv
// ----------------------------------------------------------------------------
// tb_f32div_seq
// Directed, table-driven bench for f32div_seq. Each vector is checked for its
// result and its accept-to-valid latency. Hand-written sequences cover output
// back-pressure, back-to-back handoff, and reset during an operation.
// ----------------------------------------------------------------------------
module tb_f32div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    f32div_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for in_ready, presents one operand pair, and returns 1ns after the accept edge.
    task automatic do_accept(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
        x = a; y = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 32'hDEAD_BEEF; y = 32'hDEAD_BEEF;
        check("in_ready_low_busy", {31'd0, in_ready}, 32'd0);
    endtask

    // Counts cycles after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic take_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int          lat;
        int          seen;
        logic [31:0] held;

        vecs[0]  = '{"6/2",        32'h40C0_0000, 32'h4000_0000, 32'h4040_0000};
        vecs[1]  = '{"-6/2",       32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000};
        vecs[2]  = '{"1/3",        32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB};
        vecs[3]  = '{"1/1",        32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        vecs[4]  = '{"1/0",        32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000};
        vecs[5]  = '{"0/-0",       32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000};
        vecs[6]  = '{"inf/inf",    32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000};
        vecs[7]  = '{"sub/1",      32'h0000_0001, 32'h3F80_0000, 32'h0000_0000};
        vecs[8]  = '{"overflow",   32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000};
        vecs[9]  = '{"underflow",  32'h0080_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{"-nan/-1",    32'hFFC0_0001, 32'hBF80_0000, 32'h7FC0_0000};
        vecs[11] = '{"-inf/1",     32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000};
        vecs[12] = '{"1/-inf",     32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000};
        vecs[13] = '{"2/1",        32'h4000_0000, 32'h3F80_0000, 32'h4000_0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out", out, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            do_accept(vecs[i].a, vecs[i].b);
            wait_out(lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd27);
            check(vecs[i].name, out, vecs[i].exp);
            take_out();
        end

        // Back-pressure: the result must stay put while out_ready is low.
        do_accept(32'h40C0_0000, 32'h4000_0000);
        wait_out(lat);
        held = out;
        check("bp_result", held, 32'h4040_0000);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out !== held || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        check("bp_stable", 32'(seen), 32'd0);
        take_out();
        check("out_held_in_idle", out, 32'h4040_0000);
        // Back-to-back: the accept happens on the very next edge.
        x = 32'h3F80_0000; y = 32'h4040_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_in_ready_low", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("b2b_latency", 32'(lat), 32'd27);
        check("b2b_result", out, 32'h3EAA_AAAB);
        take_out();

        // Reset 10 cycles into DIV discards the operation.
        do_accept(32'h40C0_0000, 32'h4000_0000);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #2;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        check("abort_idle_ready", {31'd0, in_ready}, 32'd1);
        do_accept(32'h40C0_0000, 32'h4000_0000);
        wait_out(lat);
        check("post_abort_latency", 32'(lat), 32'd27);
        check("post_abort_result", out, 32'h4040_0000);
        take_out();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
